async_queue_source_arbiter: RTL and testbench

Round-robin arbiter that shares the single enqueue port of an asynchronous-queue source among `N_REQ` same-clock requesters. It sits directly in front of the queue source's `io_enq` handshake and presents one zero-latency valid/ready channel to it. Once a beat is presented it holds the selection stable, and it grants bounded bursts so one requester cannot monopolise the crossing. It also counts back-pressure cycles, such as queue full or the far side in reset, for status.

---
 rtl/async_queue_source_arbiter_pkg.sv | 35 +++
 rtl/async_queue_source_arbiter_rr_pick.sv | 26 ++
 rtl/async_queue_source_arbiter.sv | 154 +++++++++++++++
 tb/tb_async_queue_source_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/async_queue_source_arbiter_pkg.sv
// Shared types and helpers for async_queue_source_arbiter.
//   arb_state_e : arbiter FSM states
//   rr_result_t : result of a rotating priority search (found flag + index)
//   rr_first()  : first set bit of 'valid' at or after 'ptr', wrapping at n
package async_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

  // Upper bound on requesters the search helper supports.
  localparam int unsigned RR_MAX_N = 32;
  localparam int unsigned RR_IDX_W = 5;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_result_t;

  function automatic rr_result_t rr_first(input logic [RR_MAX_N-1:0] valid,
                                          input logic [RR_IDX_W-1:0] ptr,
                                          input int unsigned         n);
    rr_result_t  res;
    int unsigned j;
    res = '0;
    for (int unsigned k = 0; k < RR_MAX_N; k++) begin
      j = 32'(ptr) + k;
      if (j >= n) j = j - n;
      if ((k < n) && (j < n) && !res.found && valid[j[RR_IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = j[RR_IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/async_queue_source_arbiter_rr_pick.sv
// Rotating priority encoder (purely combinational).
//   valid : per-requester request vector
//   ptr   : index with highest priority this cycle
//   idx   : first requesting index at or after ptr (wrapping)
//   found : at least one request is present
module rr_pick
  import async_arb_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  rr_result_t res;

  always_comb res = rr_first(RR_MAX_N'(valid), RR_IDX_W'(ptr), N_REQ);

  assign idx   = res.idx[IDX_W-1:0];
  // Range guard keeps the full search result meaningful; always true in range.
  assign found = res.found && ({1'b0, res.idx} < (RR_IDX_W + 1)'(N_REQ));

endmodule

// File: rtl/async_queue_source_arbiter.sv
// Round-robin arbiter in front of an async queue source enqueue port.
//   clock, reset_n      : clock, asynchronous active-low reset
//   req_valid/ready/bits: N_REQ requester channels (bits packed DATA_W each)
//   enq_valid/ready/bits: single channel to the queue source io_enq
//   grant_id            : current or last owner (registered)
//   locked              : FSM is in LOCKED (registered)
//   stall_cnt/stall_clr : saturating back-pressure cycle counter, sync clear
module async_queue_source_arbiter
  import async_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*DATA_W-1:0]    req_bits,
  output logic                       enq_valid,
  input  logic                       enq_ready,
  output logic [DATA_W-1:0]          enq_bits,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       locked,
  output logic [CNT_W-1:0]           stall_cnt,
  input  logic                       stall_clr
);

  localparam int unsigned IDX_W  = $clog2(N_REQ);
  localparam int unsigned BEAT_W = $clog2(MAX_BURST + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_REQ - 1);

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (i == LAST_IDX) ? '0 : i + 1'b1;
  endfunction

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [BEAT_W-1:0] beats_q, beats_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [CNT_W-1:0]  stall_q;

  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;
  logic [IDX_W-1:0]  sel;
  logic              sel_live;
  logic              fire;
  logic              stall;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ARB_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and datapath-next logic
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    beats_d  = beats_q;
    grant_d  = grant_q;
    case (state_q)
      ARB_IDLE: begin
        if (fire) begin
          grant_d = sel;
          if (MAX_BURST == 1) begin
            rr_ptr_d = wrap_inc(sel);
          end else begin
            state_d = ARB_LOCKED;
            owner_d = sel;
            beats_d = BEAT_W'(1);
          end
        end else if (stall) begin
          // Freeze the presented beat until the queue accepts it.
          state_d = ARB_LOCKED;
          owner_d = sel;
          beats_d = '0;
        end
      end
      ARB_LOCKED: begin
        if (fire) begin
          grant_d = owner_q;
          if (beats_q == LAST_BEAT) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = wrap_inc(owner_q);
            beats_d  = '0;
          end else begin
            beats_d = beats_q + 1'b1;
          end
        end else if (!req_valid[owner_q]) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = wrap_inc(owner_q);
          beats_d  = '0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Output logic: selection mux and per-requester ready
  always_comb begin
    sel       = (state_q == ARB_LOCKED) ? owner_q : pick_idx;
    sel_live  = (state_q == ARB_LOCKED) || pick_found;
    enq_valid = 1'b0;
    enq_bits  = '0;
    req_ready = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (sel == IDX_W'(i)) begin
        enq_valid    = req_valid[i] & sel_live;
        enq_bits     = req_bits[i*DATA_W +: DATA_W];
        req_ready[i] = enq_ready & sel_live;
      end
    end
  end

  assign fire  = enq_valid & enq_ready;
  assign stall = enq_valid & ~enq_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q <= '0;
      owner_q  <= '0;
      beats_q  <= '0;
      grant_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      beats_q  <= beats_d;
      grant_q  <= grant_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                    stall_q <= '0;
    else if (stall_clr)              stall_q <= '0;
    else if (stall && stall_q != '1) stall_q <= stall_q + 1'b1;
  end

  assign grant_id  = grant_q;
  assign locked    = (state_q == ARB_LOCKED);
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_async_queue_source_arbiter.sv
module tb_async_queue_source_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [15:0] req_bits;
  logic        enq_ready;
  logic        stall_clr;

  logic [3:0]  req_ready,  req_ready_b;
  logic        enq_valid,  enq_valid_b;
  logic [3:0]  enq_bits,   enq_bits_b;
  logic [1:0]  grant_id,   grant_id_b;
  logic        locked,     locked_b;
  logic [3:0]  stall_cnt,  stall_cnt_b;

  int checks = 0;
  int errors = 0;

  // Requester payloads: 0->3, 1->A, 2->5, 3->7
  int unsigned BITS [4] = '{3, 10, 5, 7};

  always #5 clock = ~clock;

  async_queue_source_arbiter #(
    .N_REQ(4), .DATA_W(4), .MAX_BURST(4), .CNT_W(4)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_bits(req_bits),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_bits(enq_bits),
    .grant_id(grant_id), .locked(locked),
    .stall_cnt(stall_cnt), .stall_clr(stall_clr)
  );

  async_queue_source_arbiter #(
    .N_REQ(4), .DATA_W(4), .MAX_BURST(1), .CNT_W(4)
  ) dut_b1 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready_b), .req_bits(req_bits),
    .enq_valid(enq_valid_b), .enq_ready(enq_ready), .enq_bits(enq_bits_b),
    .grant_id(grant_id_b), .locked(locked_b),
    .stall_cnt(stall_cnt_b), .stall_clr(stall_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    enq_ready = 1'b1;
    stall_clr = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    req_bits  = 16'h75A3;
    reset_n   = 1'b0;
    req_valid = '0;
    enq_ready = 1'b1;
    stall_clr = 1'b0;
    #3;
    check("rst_enq_valid", 32'(enq_valid), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_grant",     32'(grant_id),  0);
    check("rst_locked",    32'(locked),    0);
    check("rst_stall",     32'(stall_cnt), 0);
    step();
    reset_n = 1'b1;

    // Single requester, 6 beats back to back
    begin
      int exp_lock [6] = '{1, 1, 1, 0, 1, 1};
      do_reset();
      req_valid = 4'b0100;
      enq_ready = 1'b1;
      for (int b = 0; b < 6; b++) begin
        #1;
        check("t1_valid", 32'(enq_valid), 1);
        check("t1_ready", 32'(req_ready), 4);
        check("t1_bits",  32'(enq_bits),  5);
        step();
        check("t1_grant",  32'(grant_id), 2);
        check("t1_locked", 32'(locked),   32'(exp_lock[b]));
      end
    end

    // All valid: bursts of 4 in rotation; MAX_BURST=1 instance rotates every beat
    do_reset();
    req_valid = 4'b1111;
    enq_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      int e0, e1;
      e0 = (c / 4) % 4;
      e1 = c % 4;
      #1;
      check("t2_ready",   32'(req_ready),   32'(1 << e0));
      check("t2_bits",    32'(enq_bits),    BITS[e0]);
      check("t2b_ready",  32'(req_ready_b), 32'(1 << e1));
      check("t2b_bits",   32'(enq_bits_b),  BITS[e1]);
      step();
      check("t2_grant",   32'(grant_id),    32'(e0));
      check("t2b_grant",  32'(grant_id_b),  32'(e1));
      check("t2b_locked", 32'(locked_b),    0);
    end

    // Stall: requester 1 held 10 cycles, requester 0 arrives meanwhile
    do_reset();
    req_valid = 4'b0010;
    enq_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) req_valid = 4'b0011;
      #1;
      check("t3_bits",  32'(enq_bits),  10);
      check("t3_ready", 32'(req_ready), 0);
      step();
      check("t3_locked", 32'(locked), 1);
    end
    check("t3_stall", 32'(stall_cnt), 10);
    enq_ready = 1'b1;
    #1;
    check("t3_fire_ready", 32'(req_ready), 2);
    check("t3_fire_bits",  32'(enq_bits),  10);
    step();
    check("t3_stall_hold", 32'(stall_cnt), 10);
    check("t3_grant",      32'(grant_id),  1);
    req_valid = 4'b0001;
    #1;
    check("t3_drop_valid", 32'(enq_valid), 0);
    step();
    check("t3_release", 32'(locked), 0);
    #1;
    check("t3_next_ready", 32'(req_ready), 1);
    check("t3_next_bits",  32'(enq_bits),  3);
    step();
    check("t3_next_grant", 32'(grant_id), 0);

    // Early release: owner 3 drops after 2 beats, requester 0 pending
    do_reset();
    enq_ready = 1'b1;
    req_valid = 4'b1000;
    #1;
    check("t4_b0_ready", 32'(req_ready), 8);
    step();
    req_valid = 4'b1001;
    #1;
    check("t4_b1_ready", 32'(req_ready), 8);
    step();
    check("t4_locked", 32'(locked), 1);
    req_valid = 4'b0001;
    #1;
    check("t4_drop_valid", 32'(enq_valid), 0);
    step();
    check("t4_idle", 32'(locked), 0);
    #1;
    check("t4_r0_valid", 32'(enq_valid), 1);
    check("t4_r0_ready", 32'(req_ready), 1);
    check("t4_r0_bits",  32'(enq_bits),  3);
    step();
    check("t4_r0_grant",  32'(grant_id), 0);
    check("t4_r0_locked", 32'(locked),   1);

    // Reset mid-burst of owner 1, after some stall cycles
    do_reset();
    req_valid = 4'b0010;
    enq_ready = 1'b0;
    step();
    step();
    enq_ready = 1'b1;
    step();
    step();
    check("t5_pre_grant",  32'(grant_id),  1);
    check("t5_pre_locked", 32'(locked),    1);
    check("t5_pre_stall",  32'(stall_cnt), 2);
    reset_n = 1'b0;
    #1;
    check("t5_async_locked", 32'(locked),    0);
    check("t5_async_grant",  32'(grant_id),  0);
    check("t5_async_stall",  32'(stall_cnt), 0);
    step();
    reset_n   = 1'b1;
    req_valid = 4'b1111;
    #1;
    check("t5_restart_ready", 32'(req_ready), 1);
    step();
    check("t5_restart_grant", 32'(grant_id),  0);
    check("t5_restart_stall", 32'(stall_cnt), 0);

    // Saturation and clear priority
    do_reset();
    req_valid = 4'b0001;
    enq_ready = 1'b0;
    repeat (20) step();
    check("t6_sat", 32'(stall_cnt), 15);
    stall_clr = 1'b1;
    step();
    check("t6_clr", 32'(stall_cnt), 0);
    stall_clr = 1'b0;
    step();
    check("t6_resume", 32'(stall_cnt), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
